neuron_layer_sequencer: RTL and testbench
=========================================

# neuron_layer_sequencer

Controller that time-sequences one `neuron_layer` instance between a serial activation stream and a serial result stream. It collects NEURON_INPUTS serial words into a parallel buffer, issues them to the layer with a valid/ready handshake, and captures each neuron's result as its valid bit rises. It then streams the NUM_NEURONS results out one word per beat. It sits between the previous pipeline stage (flatten/pool output) and the next layer or classifier head.

## Interface
- DATA_WIDTH, 32, word width; fixed-point, passed through untouched
- NUM_NEURONS, 2, neurons in the driven layer; must be ≥1
- NEURON_INPUTS, 32, inputs per neuron (buffer depth); must be ≥2
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- seq_valid_in  in  1  upstream word valid
- seq_ready_in  out  1  sequencer can accept an upstream word
- seq_data_in  in  DATA_WIDTH  upstream word
- seq_valid_out  out  1  result word valid
- seq_ready_out  in  1  downstream accepts result
- seq_data_out  out  DATA_WIDTH  result word (neuron seq_index_out)
- seq_index_out  out  $clog2(NUM_NEURONS) (min 1)  neuron index of current result
- seq_last_out  out  1  high with the result of neuron NUM_NEURONS-1
- layer_valid_in  out  1  drives neuron_layer_valid_in
- layer_ready_in  in  1  from neuron_layer_ready_in
- layer_data_in  out  DATA_WIDTH × [0:NEURON_INPUTS-1]  drives neuron_layer_data_in
- layer_ready_out  out  1  drives neuron_layer_ready_out
- layer_valid_out  in  NUM_NEURONS  from neuron_layer_valid_out
- layer_data_out  in  DATA_WIDTH × [0:NUM_NEURONS-1]  from neuron_layer_data_out

## Operation
- States: LOAD → ISSUE → WAIT → DRAIN → LOAD.
- LOAD: seq_ready_in=1. Each handshake (valid&ready) writes buffer[wr_idx] and increments wr_idx. The handshake at wr_idx==NEURON_INPUTS-1 clears wr_idx and moves the state to ISSUE.
- ISSUE: layer_valid_in=1 and layer_data_in=buffer, held stable. A handshake with layer_ready_in moves the state to WAIT.
- WAIT: layer_ready_out=1. For each bit n with layer_valid_out[n]=1 and captured[n]=0, latch layer_data_out[n] into result[n] and set captured[n]. Later changes on an already-captured neuron are ignored. When every bit of captured, counting same-cycle captures, is set, move to DRAIN.
- DRAIN: seq_valid_out=1, seq_data_out=result[rd_idx], seq_index_out=rd_idx, seq_last_out=(rd_idx==NUM_NEURONS-1). Each handshake increments rd_idx. The last handshake clears rd_idx and captured and moves the state to LOAD.
- layer_data_in is always driven from the buffer. The buffer changes only in LOAD.
- Words pass through bit-exact; no arithmetic on data. wr_idx width is $clog2(NEURON_INPUTS); rd_idx width is $clog2(NUM_NEURONS) (min 1). Neither index wraps past its terminal value.
- Input valid during ISSUE/WAIT/DRAIN is back-pressured (seq_ready_in=0); no words are dropped.

## Timing
- All state, indices, buffer, results and the four handshake-control outputs are registered. Data outputs are mux reads of registers.
- Reset values (async, while rst_n=0): state=LOAD, all indices 0, captured=0. seq_ready_in, seq_valid_out, seq_last_out, layer_valid_in and layer_ready_out are 0. seq_index_out=0. Buffer and result are cleared to 0.
- seq_ready_in rises on the first clk edge after rst_n deasserts.
- Load: NEURON_INPUTS cycles minimum at one word/cycle.
- layer_valid_in asserts the cycle after the final input handshake.
- WAIT is entered the cycle after the layer handshake. A neuron whose valid is already high is captured on that first WAIT cycle.
- seq_valid_out asserts the cycle after the last capture.
- Drain: NUM_NEURONS cycles minimum. seq_ready_in reasserts the cycle after the seq_last_out handshake.
- Back-pressure at any stage holds all state, indices and outputs unchanged.
- rst_n asserted mid-operation aborts immediately. The partial buffer and results are discarded, and no stale result is emitted after reset.

## Structure
- cnn1d_pkg: typedef enum logic [1:0] seq_state_t {LOAD, ISSUE, WAIT, DRAIN}.
- Single module; no sub-module needed. Buffer and result arrays are flops, not RAM, because all words are needed in parallel.

## Test plan
- Basic frame: stub layer with ready_in=1, replying after 5 cycles with all valid_out high. Send words i<<24 for i=0..31. Required: layer_data_in[i]=i<<24 at ISSUE. Outputs are result 0, index 0, then index 1 with last=1.
- Staggered completion: layer asserts valid_out[1] 3 cycles before valid_out[0]. Required: both results captured, DRAIN entered only after bit 0 is captured, output order is still index 0 then 1.
- Back-pressure: upstream valid toggles every other cycle, layer_ready_in is held low 4 cycles in ISSUE, and seq_ready_out is low 3 cycles mid-drain. Required: no lost or duplicated words, and layer_data_in is stable throughout ISSUE.
- Input blocked: hold seq_valid_in=1 with fresh data during WAIT/DRAIN. Required: seq_ready_in=0 and the buffer is unchanged until LOAD.
- Reset mid-load: assert rst_n=0 after 10 words. Required: outputs are at reset values immediately, seq_ready_in=1 one edge after release, and a fresh 32-word frame produces correct results.
- Back-to-back frames: two frames with distinct data and seq_ready_out tied to 1. Required: the second frame's results match its own data, and the captured bits are cleared between frames.

Source files
------------

// File: rtl/cnn1d_pkg.sv
// Shared types for the 1-D CNN datapath blocks.
package cnn1d_pkg;

    // Sequencer phases: gather inputs, hand them to the layer, collect results, stream results out.
    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } seq_state_t;

    // Index width for a count of n items; a single item still gets one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/neuron_layer_sequencer.sv
// Time-sequences one neuron_layer: serial words in -> parallel issue -> per-neuron capture -> serial results out.
module neuron_layer_sequencer
    import cnn1d_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_NEURONS   = 2,
    parameter int NEURON_INPUTS = 32,
    localparam int RD_W         = idx_w(NUM_NEURONS),
    localparam int WR_W         = $clog2(NEURON_INPUTS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  seq_valid_in,
    output logic                  seq_ready_in,
    input  logic [DATA_WIDTH-1:0] seq_data_in,
    output logic                  seq_valid_out,
    input  logic                  seq_ready_out,
    output logic [DATA_WIDTH-1:0] seq_data_out,
    output logic [RD_W-1:0]       seq_index_out,
    output logic                  seq_last_out,
    output logic                  layer_valid_in,
    input  logic                  layer_ready_in,
    output logic [DATA_WIDTH-1:0] layer_data_in [0:NEURON_INPUTS-1],
    output logic                  layer_ready_out,
    input  logic [NUM_NEURONS-1:0] layer_valid_out,
    input  logic [DATA_WIDTH-1:0] layer_data_out [0:NUM_NEURONS-1]
);

    localparam logic [WR_W-1:0] WR_LAST = WR_W'(NEURON_INPUTS - 1);
    localparam logic [RD_W-1:0] RD_LAST = RD_W'(NUM_NEURONS - 1);

    seq_state_t             r_state;
    seq_state_t             w_state_nxt;
    logic [WR_W-1:0]        r_wr_idx;
    logic [RD_W-1:0]        r_rd_idx;
    logic [NUM_NEURONS-1:0] r_captured;
    logic [NUM_NEURONS-1:0] w_cap_nxt;
    logic [DATA_WIDTH-1:0]  r_buf    [0:NEURON_INPUTS-1];
    logic [DATA_WIDTH-1:0]  r_result [0:NUM_NEURONS-1];

    logic r_seq_ready_in;
    logic r_seq_valid_out;
    logic r_layer_valid_in;
    logic r_layer_ready_out;

    logic w_load_hs;
    logic w_issue_hs;
    logic w_drain_hs;
    logic w_wr_last;
    logic w_rd_last;

    assign w_load_hs  = r_seq_ready_in & seq_valid_in;
    assign w_issue_hs = r_layer_valid_in & layer_ready_in;
    assign w_drain_hs = r_seq_valid_out & seq_ready_out;
    assign w_wr_last  = (r_wr_idx == WR_LAST);
    assign w_rd_last  = (r_rd_idx == RD_LAST);
    // Same-cycle captures count toward completion so DRAIN follows the last capture directly.
    assign w_cap_nxt  = r_captured | (layer_valid_out & {NUM_NEURONS{r_layer_ready_out}});

    // Next-state decode for the four-phase frame sequence.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            LOAD:    if (w_load_hs && w_wr_last) w_state_nxt = ISSUE;
            ISSUE:   if (w_issue_hs)             w_state_nxt = WAIT;
            WAIT:    if (&w_cap_nxt)             w_state_nxt = DRAIN;
            DRAIN:   if (w_drain_hs && w_rd_last) w_state_nxt = LOAD;
            default: w_state_nxt = LOAD;
        endcase
    end

    // State plus registered handshake controls, decoded from the next state so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state           <= LOAD;
            r_seq_ready_in    <= 1'b0;
            r_layer_valid_in  <= 1'b0;
            r_layer_ready_out <= 1'b0;
            r_seq_valid_out   <= 1'b0;
        end else begin
            r_state           <= w_state_nxt;
            r_seq_ready_in    <= (w_state_nxt == LOAD);
            r_layer_valid_in  <= (w_state_nxt == ISSUE);
            r_layer_ready_out <= (w_state_nxt == WAIT);
            r_seq_valid_out   <= (w_state_nxt == DRAIN);
        end
    end

    // Write index: advances per accepted word, returns to 0 on the final word of a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_idx <= '0;
        end else if (w_load_hs) begin
            r_wr_idx <= w_wr_last ? '0 : r_wr_idx + 1'b1;
        end
    end

    // Read index: advances per accepted result, returns to 0 after the last neuron.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_idx <= '0;
        end else if (w_drain_hs) begin
            r_rd_idx <= w_rd_last ? '0 : r_rd_idx + 1'b1;
        end
    end

    // Input buffer: written only by LOAD handshakes, so it stays stable through ISSUE/WAIT/DRAIN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NEURON_INPUTS; i++) r_buf[i] <= '0;
        end else if (w_load_hs) begin
            r_buf[r_wr_idx] <= seq_data_in;
        end
    end

    // Capture flags: accumulate during WAIT, cleared once the last result leaves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_captured <= '0;
        end else if (r_state == WAIT) begin
            r_captured <= w_cap_nxt;
        end else if (w_drain_hs && w_rd_last) begin
            r_captured <= '0;
        end
    end

    // Result latches: first valid per neuron wins; later changes on that neuron are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int n = 0; n < NUM_NEURONS; n++) r_result[n] <= '0;
        end else begin
            for (int n = 0; n < NUM_NEURONS; n++) begin
                if (r_layer_ready_out && layer_valid_out[n] && !r_captured[n]) begin
                    r_result[n] <= layer_data_out[n];
                end
            end
        end
    end

    assign seq_ready_in    = r_seq_ready_in;
    assign seq_valid_out   = r_seq_valid_out;
    assign seq_data_out    = r_result[r_rd_idx];
    assign seq_index_out   = r_rd_idx;
    assign seq_last_out    = r_seq_valid_out & w_rd_last;
    assign layer_valid_in  = r_layer_valid_in;
    assign layer_ready_out = r_layer_ready_out;
    assign layer_data_in   = r_buf;

endmodule

// File: tb/tb_neuron_layer_sequencer.sv
// Directed bench for neuron_layer_sequencer with a stub neuron_layer driven from a frame table.
module tb_neuron_layer_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        seq_valid_in = 1'b0;
    logic        seq_ready_in;
    logic [31:0] seq_data_in = '0;
    logic        seq_valid_out;
    logic        seq_ready_out = 1'b0;
    logic [31:0] seq_data_out;
    logic [0:0]  seq_index_out;
    logic        seq_last_out;
    logic        layer_valid_in;
    logic        layer_ready_in = 1'b0;
    logic [31:0] layer_data_in [0:31];
    logic        layer_ready_out;
    logic [1:0]  layer_valid_out = '0;
    logic [31:0] layer_data_out [0:1];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    neuron_layer_sequencer #(
        .DATA_WIDTH(32), .NUM_NEURONS(2), .NEURON_INPUTS(32)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .seq_valid_in(seq_valid_in), .seq_ready_in(seq_ready_in), .seq_data_in(seq_data_in),
        .seq_valid_out(seq_valid_out), .seq_ready_out(seq_ready_out), .seq_data_out(seq_data_out),
        .seq_index_out(seq_index_out), .seq_last_out(seq_last_out),
        .layer_valid_in(layer_valid_in), .layer_ready_in(layer_ready_in), .layer_data_in(layer_data_in),
        .layer_ready_out(layer_ready_out), .layer_valid_out(layer_valid_out), .layer_data_out(layer_data_out)
    );

    // One frame: upstream pattern, stub-layer behaviour, and the required results/latency.
    typedef struct {
        logic [31:0] base;   // word i = base | (i << 24)
        bit          gap;    // idle cycle between upstream words
        int          hold;   // cycles layer_ready_in stays low in ISSUE
        int          d0;     // WAIT cycle on which valid_out[0] rises
        int          d1;     // WAIT cycle on which valid_out[1] rises
        int          stall;  // cycles seq_ready_out low before the second result
        bit          blk;    // push junk upstream words during WAIT/DRAIN
        bit          tie;    // seq_ready_out tied high
        logic [31:0] r0;
        logic [31:0] r1;
        int          lat;    // WAIT cycles until seq_valid_out is seen
        logic [31:0] e0;
        logic [31:0] e1;
    } vec_t;

    vec_t tbl [0:5];

    function automatic logic [31:0] word_of(input logic [31:0] base, input int i);
        return base | (32'(i) << 24);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic chk_buf(input string name, input logic [31:0] base);
        int bad = 0;
        for (int i = 0; i < 32; i++) if (layer_data_in[i] !== word_of(base, i)) bad++;
        chk(name, 32'(bad), 32'd0);
    endtask

    task automatic send_word(input logic [31:0] w);
        int b = 0;
        @(negedge clk);
        seq_valid_in = 1'b1;
        seq_data_in  = w;
        while (!seq_ready_in) begin
            @(negedge clk);
            b++;
            if (b > 20) begin
                $display("FAIL load_timeout: seq_ready_in stayed %b, required 1", seq_ready_in);
                $fatal(1, "timeout");
            end
        end
        @(posedge clk);
    endtask

    task automatic run_frame(input int f);
        vec_t v;
        int   t;
        v = tbl[f];
        seq_ready_out = v.tie;
        for (int i = 0; i < 32; i++) begin
            if (v.gap && i > 0) begin
                @(negedge clk);
                seq_valid_in = 1'b0;
                @(posedge clk);
            end
            send_word(word_of(v.base, i));
        end
        @(negedge clk);
        seq_valid_in = 1'b0;
        chk("issue_valid", 32'(layer_valid_in), 32'd1);
        chk("issue_ready_in_low", 32'(seq_ready_in), 32'd0);
        chk_buf("issue_buf", v.base);
        for (int h = 0; h < v.hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            chk("issue_hold_valid", 32'(layer_valid_in), 32'd1);
            chk_buf("issue_hold_buf", v.base);
        end
        layer_ready_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        layer_ready_in = 1'b0;
        chk("wait_ready_out", 32'(layer_ready_out), 32'd1);
        chk("wait_valid_in_low", 32'(layer_valid_in), 32'd0);

        t = 0;
        while (!seq_valid_out) begin
            if (t > 40) begin
                $display("FAIL wait_timeout: seq_valid_out stayed %b, required 1", seq_valid_out);
                $fatal(1, "timeout");
            end
            if (t == v.d0) begin
                layer_valid_out[0] = 1'b1;
                layer_data_out[0]  = v.r0;
            end else if (t == v.d0 + 1) begin
                layer_data_out[0]  = ~v.r0;
            end
            if (t == v.d1) begin
                layer_valid_out[1] = 1'b1;
                layer_data_out[1]  = v.r1;
            end else if (t == v.d1 + 1) begin
                layer_data_out[1]  = ~v.r1;
            end
            if (v.blk) begin
                chk("blocked_ready_in", 32'(seq_ready_in), 32'd0);
                seq_valid_in = 1'b1;
                seq_data_in  = 32'hDEAD0000 | 32'(t);
            end
            @(posedge clk);
            @(negedge clk);
            t++;
        end
        chk("drain_latency", 32'(t), 32'(v.lat));
        layer_valid_out   = '0;
        layer_data_out[0] = '0;
        layer_data_out[1] = '0;

        for (int k = 0; k < 2; k++) begin
            if (k == 1) begin
                for (int s = 0; s < v.stall; s++) begin
                    seq_ready_out = 1'b0;
                    chk("stall_valid", 32'(seq_valid_out), 32'd1);
                    chk("stall_data", seq_data_out, v.e1);
                    chk("stall_index", 32'(seq_index_out), 32'd1);
                    @(posedge clk);
                    @(negedge clk);
                end
            end
            chk("out_valid", 32'(seq_valid_out), 32'd1);
            chk("out_data", seq_data_out, (k == 0) ? v.e0 : v.e1);
            chk("out_index", 32'(seq_index_out), 32'(k));
            chk("out_last", 32'(seq_last_out), 32'(k == 1));
            if (v.blk) begin
                chk("drain_blocked_ready_in", 32'(seq_ready_in), 32'd0);
                chk_buf("drain_buf_unchanged", v.base);
                if (k == 1) seq_valid_in = 1'b0;
            end
            seq_ready_out = 1'b1;
            @(posedge clk);
            @(negedge clk);
            seq_ready_out = v.tie;
        end
        chk("post_drain_valid", 32'(seq_valid_out), 32'd0);
        chk("reload_ready_in", 32'(seq_ready_in), 32'd1);
    endtask

    initial begin
        layer_data_out[0] = '0;
        layer_data_out[1] = '0;
        //           base          gap  hold d0 d1 stl blk  tie  r0            r1            lat e0            e1
        tbl[0] = '{32'h0000_0000, 1'b0, 0, 5, 5, 0, 1'b0, 1'b0, 32'h1111_0000, 32'h2222_0001, 6, 32'h1111_0000, 32'h2222_0001};
        tbl[1] = '{32'h0000_0101, 1'b0, 0, 4, 1, 0, 1'b0, 1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 5, 32'h8000_0000, 32'h7FFF_FFFF};
        tbl[2] = '{32'h0000_A5A5, 1'b1, 4, 2, 2, 3, 1'b0, 1'b0, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 3, 32'hA5A5_A5A5, 32'h5A5A_5A5A};
        tbl[3] = '{32'h0000_0F0F, 1'b0, 0, 0, 0, 0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1, 32'hFFFF_FFFF, 32'h0000_0000};
        tbl[4] = '{32'h00AB_CDEF, 1'b0, 0, 1, 3, 0, 1'b0, 1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 4, 32'h1234_5678, 32'h9ABC_DEF0};
        tbl[5] = '{32'h0012_3456, 1'b0, 0, 2, 0, 0, 1'b0, 1'b1, 32'h0BAD_F00D, 32'hCAFE_BABE, 3, 32'h0BAD_F00D, 32'hCAFE_BABE};

        // Power-on reset state, then ready one edge after release.
        repeat (3) @(negedge clk);
        chk("rst_ready_in", 32'(seq_ready_in), 32'd0);
        chk("rst_valid_out", 32'(seq_valid_out), 32'd0);
        chk("rst_last", 32'(seq_last_out), 32'd0);
        chk("rst_index", 32'(seq_index_out), 32'd0);
        chk("rst_layer_valid_in", 32'(layer_valid_in), 32'd0);
        chk("rst_layer_ready_out", 32'(layer_ready_out), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("release_ready_in_low", 32'(seq_ready_in), 32'd0);
        @(negedge clk);
        chk("release_ready_in_high", 32'(seq_ready_in), 32'd1);

        for (int f = 0; f < 4; f++) run_frame(f);

        // Reset in the middle of a load: partial buffer discarded, outputs return to reset values at once.
        for (int i = 0; i < 10; i++) send_word(word_of(32'h0055_5555, i));
        #2;
        seq_valid_in = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_ready_in", 32'(seq_ready_in), 32'd0);
        chk("midrst_valid_out", 32'(seq_valid_out), 32'd0);
        chk("midrst_last", 32'(seq_last_out), 32'd0);
        chk("midrst_index", 32'(seq_index_out), 32'd0);
        chk("midrst_layer_valid_in", 32'(layer_valid_in), 32'd0);
        chk("midrst_layer_ready_out", 32'(layer_ready_out), 32'd0);
        chk("midrst_buf0", layer_data_in[0], 32'd0);
        chk("midrst_buf9", layer_data_in[9], 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_release_ready_in", 32'(seq_ready_in), 32'd1);

        // Fresh frame after reset, then a back-to-back frame with the output side always ready.
        run_frame(4);
        run_frame(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
